// File: rtl/imm_pkg.sv
// Shared encodings for the immediate extender: fill modes, skid states, width limits.
package imm_pkg;

  localparam logic [1:0] IMM_MODE_SEXT  = 2'b00;
  localparam logic [1:0] IMM_MODE_ZEXT  = 2'b01;
  localparam logic [1:0] IMM_MODE_ONES  = 2'b10;
  localparam logic [1:0] IMM_MODE_UPPER = 2'b11;

  localparam int MIN_IN_W  = 1;
  localparam int MAX_OUT_W = 32;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic bit widths_legal(input int in_w, input int out_w);
    return (in_w >= MIN_IN_W) && (in_w <= out_w) && (out_w <= MAX_OUT_W);
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate widening in one of four fill modes; with IMM_SHIFT_EN the
// widened value is then shifted left by a shift amount, zeroing when the amount reaches OUT_W.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic [IN_W-1:0]    imm,
  input  logic [1:0]         mode,
`ifdef IMM_SHIFT_EN
  input  logic [SHAMT_W-1:0] shamt,
`endif
  output logic [OUT_W-1:0]   ext
);

  localparam logic [OUT_W-1:0] LO_MASK = OUT_W'({IN_W{1'b1}});

  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] widened;

  assign base = OUT_W'(imm);

  // With IN_W == OUT_W the high mask is empty and the upper shift is zero, so every mode passes imm through.
  always_comb begin
    widened = base;
    case (mode)
      IMM_MODE_SEXT:  widened = imm[IN_W-1] ? (base | ~LO_MASK) : base;
      IMM_MODE_ZEXT:  widened = base;
      IMM_MODE_ONES:  widened = base | ~LO_MASK;
      IMM_MODE_UPPER: widened = base << (OUT_W - IN_W);
      default:        widened = base;
    endcase
  end

`ifdef IMM_SHIFT_EN
  always_comb begin
    ext = '0;
    if (32'(shamt) < OUT_W) ext = widened << shamt;
  end
`else
  assign ext = widened;
`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Handshaked immediate extender: 1-cycle latency into a registered output stage backed by a
// 1-entry skid; in_ready is a flop so out_ready never reaches it combinationally. Option: IMM_SHIFT_EN.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_imm,
  input  logic [1:0]         in_mode,
`ifdef IMM_SHIFT_EN
  input  logic [SHAMT_W-1:0] in_shamt,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_imm
);

  if (!widths_legal(IN_W, OUT_W)) begin : g_bad_widths
    $error("imm_extend_pipe: illegal IN_W/OUT_W combination");
  end

  skid_state_e      state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_imm_q, out_imm_d;
  logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
  logic             skid_empty_q, skid_empty_d;
  logic [OUT_W-1:0] ext;
  logic             in_fire;
  logic             out_fire;

  imm_extend_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .imm   (in_imm),
    .mode  (in_mode),
`ifdef IMM_SHIFT_EN
    .shamt (in_shamt),
`endif
    .ext   (ext)
  );

  // skid_empty_q resets to 1 so in_ready rises in the very first cycle after reset drops.
  assign in_ready  = ~reset & skid_empty_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    skid_imm_d   = skid_imm_q;
    skid_empty_d = skid_empty_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d     = SKID_ONE;
          out_valid_d = 1'b1;
          out_imm_d   = ext;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          out_imm_d = ext;
        end else if (in_fire) begin
          state_d      = SKID_FULL;
          skid_imm_d   = ext;
          skid_empty_d = 1'b0;
        end else if (out_fire) begin
          state_d     = SKID_EMPTY;
          out_valid_d = 1'b0;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d      = SKID_ONE;
          out_imm_d    = skid_imm_q;
          skid_empty_d = 1'b1;
        end
      end
      default: begin
        state_d      = SKID_EMPTY;
        out_valid_d  = 1'b0;
        skid_empty_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SKID_EMPTY;
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      skid_imm_q   <= '0;
      skid_empty_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      skid_imm_q   <= skid_imm_d;
      skid_empty_q <= skid_empty_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode/latency/skid/reset cases plus a
// randomized stream scored against an arithmetic reference model.
module tb_imm_extend_pipe;

  int total = 0;
  int bad   = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_imm = 2'b00;
  logic [1:0] in_mode = 2'b00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_imm;

  logic [7:0] expq[$];

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
`ifdef IMM_SHIFT_EN
    .in_shamt  (3'd0),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm)
  );

`ifdef IMM_SHIFT_EN
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [3:0]  s_in_imm = 4'h0;
  logic [1:0]  s_in_mode = 2'b00;
  logic [4:0]  s_in_shamt = 5'd0;
  logic        s_out_valid;
  logic [15:0] s_out_imm;

  imm_extend_pipe #(.IN_W(4), .OUT_W(16), .SHAMT_W(5)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_imm    (s_in_imm),
    .in_mode   (s_in_mode),
    .in_shamt  (s_in_shamt),
    .out_valid (s_out_valid),
    .out_ready (1'b1),
    .out_imm   (s_out_imm)
  );
`endif

  // Reference: interpret imm as a number, widen by arithmetic on the value, mask to outw bits.
  function automatic longint ref_ext(input int imm, input int mode, input int inw, input int outw);
    longint mask;
    longint v;
    mask = (longint'(1) << outw) - 1;
    case (mode)
      0: v = (imm >= (1 << (inw - 1))) ? longint'(imm) - (longint'(1) << inw) : longint'(imm);
      1: v = imm;
      2: v = longint'(imm) + (mask + 1) - (longint'(1) << inw);
      default: v = longint'(imm) * (longint'(1) << (outw - inw));
    endcase
    return v & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (out_valid !== 1'b0 || out_imm !== 8'h00 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b out_imm=%h in_ready=%b want 0/00/0", out_valid, out_imm, in_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_sext_seq();
    logic [1:0] imms[4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [7:0] exps[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_imm   = imms[i];
      in_mode  = 2'b00;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_imm !== exps[i]) begin
        bad++;
        $display("FAIL sext_%0d: out_valid=%b out_imm=%h want 1/%h", i, out_valid, out_imm, exps[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sext_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_modes();
    logic [1:0] imms[4]  = '{2'b10, 2'b10, 2'b10, 2'b01};
    logic [1:0] modes[4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [7:0] exps[4]  = '{8'h02, 8'hFE, 8'h80, 8'hFD};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_imm   = imms[i];
      in_mode  = modes[i];
      tick();
      total++;
      if (out_valid !== 1'b1 || out_imm !== exps[i]) begin
        bad++;
        $display("FAIL mode_%0d: out_valid=%b out_imm=%h want 1/%h", i, out_valid, out_imm, exps[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_imm    = 2'b01;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_imm !== 8'h01 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_first: out_valid=%b out_imm=%h in_ready=%b want 1/01/1", out_valid, out_imm, in_ready);
    end
    in_imm = 2'b10;
    tick();
    total++;
    if (in_ready !== 1'b0 || out_imm !== 8'h01) begin
      bad++;
      $display("FAIL stall_full: in_ready=%b out_imm=%h want 0/01", in_ready, out_imm);
    end
    in_imm = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 8'h01) begin
        bad++;
        $display("FAIL stall_hold_%0d: in_ready=%b out_valid=%b out_imm=%h want 0/1/01", i, in_ready, out_valid, out_imm);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_imm !== 8'hFE || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_second: out_valid=%b out_imm=%h in_ready=%b want 1/fe/1", out_valid, out_imm, in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_imm !== 8'hFF) begin
      bad++;
      $display("FAIL stall_third: out_valid=%b out_imm=%h want 1/ff", out_valid, out_imm);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  // Continuous input stream of random immediates/modes against a toggling out_ready, scored by queue.
  task automatic test_back_to_back(input int n);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [1:0] imm_r;
    logic [1:0] mode_r;
    logic [7:0] e;
    expq.delete();
    imm_r  = 2'($urandom_range(0, 3));
    mode_r = 2'($urandom_range(0, 3));
    while ((sent < n || got < sent) && cyc < 400) begin
      in_valid  = (sent < n);
      in_imm    = imm_r;
      in_mode   = mode_r;
      out_ready = (cyc % 2 == 0);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected output %h", out_imm);
        end else begin
          e = expq.pop_front();
          if (out_imm !== e) begin
            bad++;
            $display("FAIL b2b_data_%0d: got %h want %h", got, out_imm, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(8'(ref_ext(int'(imm_r), int'(mode_r), 2, 8)));
        sent++;
        imm_r  = 2'($urandom_range(0, 3));
        mode_r = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got !== n || expq.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs, queue left %0d, want %0d/0", got, expq.size(), n);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b10;
    in_imm    = 2'b00;
    tick();
    in_imm = 2'b01;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_imm !== 8'h00 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: out_valid=%b out_imm=%h in_ready=%b want 0/00/0", out_valid, out_imm, in_ready);
    end
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b11;
    in_imm    = 2'b01;
    #1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_imm !== 8'h40) begin
      bad++;
      $display("FAIL reset_first_out: out_valid=%b out_imm=%h want 1/40", out_valid, out_imm);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_stale: out_valid=%b want 0", out_valid);
    end
  endtask

`ifdef IMM_SHIFT_EN
  task automatic test_shift();
    logic [3:0]  imms[3]   = '{4'hA, 4'hA, 4'h3};
    logic [1:0]  modes[3]  = '{2'b00, 2'b01, 2'b10};
    logic [4:0]  shamts[3] = '{5'd3, 5'd7, 5'd16};
    logic [15:0] exps[3]   = '{16'hFFD0, 16'h0500, 16'h0000};
    logic [15:0] e;
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1;
      s_in_imm   = imms[i];
      s_in_mode  = modes[i];
      s_in_shamt = shamts[i];
      tick();
      total++;
      if (s_out_valid !== 1'b1 || s_out_imm !== exps[i]) begin
        bad++;
        $display("FAIL shift_%0d: out_valid=%b out_imm=%h want 1/%h", i, s_out_valid, s_out_imm, exps[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      s_in_imm   = 4'($urandom_range(0, 15));
      s_in_mode  = 2'($urandom_range(0, 3));
      s_in_shamt = 5'($urandom_range(0, 20));
      e = (s_in_shamt >= 5'd16) ? 16'h0000
          : 16'(ref_ext(int'(s_in_imm), int'(s_in_mode), 4, 16) << s_in_shamt);
      tick();
      total++;
      if (s_out_imm !== e) begin
        bad++;
        $display("FAIL shift_rand_%0d: out_imm=%h want %h", i, s_out_imm, e);
      end
    end
    s_in_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sext_seq();
    test_modes();
    test_stall_skid();
    test_back_to_back(20);
    test_back_to_back(40);
    test_reset_mid();
`ifdef IMM_SHIFT_EN
    test_shift();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
